operand_sequencer: RTL and testbench
====================================

# operand_sequencer

Sequences operand parsing for one assembly line after the mnemonic has been decoded. It consumes the remaining ASCII characters of the line, walks the operand list dictated by the instruction format (register, register, register / immediate), and validates each field. It produces rd, rs1, rs2 and a sign-extended immediate for the instruction encoder. It sits between the mnemonic decoder, which issues `start` and `format`, and the encoder, which consumes `done_flag` and the fields.

## Interface

- `IMM_W`, 20: width of the `imm` output.
- `clk_in`  input  1  system clock.
- `rst_in`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle pulse; begins a new operand list; has priority over everything else.
- `format`  input  2  sampled on `start`. 0 = R (reg, reg, reg); 1 = I (reg, reg, imm); 2 = U (reg, imm); 3 = illegal.
- `char_valid`  input  1  `char_in` is valid this cycle; one character is consumed per valid cycle.
- `char_in`  input  8  ASCII character.
- `busy`  output  1  high from the cycle after `start` until DONE/ERROR is reached.
- `done_flag`  output  1  one-cycle pulse; the line parsed successfully.
- `error_flag`  output  1  high while in ERROR; sticky until `start` or reset.
- `rd`, `rs1`, `rs2`  output  5 each  register numbers.
- `imm`  output  IMM_W  immediate, two's complement and sign-extended to IMM_W.

## Operation

- States: IDLE, OPERAND (expecting operand start), REG_D1, REG_D2, REG_END, IMM_FIRST, IMM_DIGITS, SEP, DONE, ERROR.
- `start`: latch `format`, clear all field outputs, the operand index and the accumulator, then go to OPERAND. If `format == 3`, go to ERROR instead.
- OPERAND:
  - ' ' is skipped.
  - If the current slot is a register, 'r'/'R' goes to REG_D1.
  - If the current slot is an immediate, '-' goes to IMM_FIRST with neg set, and a digit goes to IMM_DIGITS.
  - Anything else goes to ERROR.
  - Slot order: R = rd, rs1, rs2. I = rd, rs1, imm. U = rd, imm.
- Registers:
  - Exactly two decimal digits.
  - REG_D1 accepts '0'..'3' and stores d1 × 10.
  - REG_D2 accepts '0'..'9'. It adds d2 and errors if the sum exceeds 31.
  - REG_END requires ' ', ',' or '\n' (0x0A). The delimiter is then handled as in SEP in the same cycle.
- Immediates:
  - IMM_FIRST requires a digit.
  - IMM_DIGITS accumulates magnitude as acc × 10 + digit into a 21-bit unsigned register.
  - ERROR is raised the cycle a digit makes the magnitude exceed the limit:
    - I: 2047 positive, 2048 negative.
    - U: 1048575.
  - '-' is illegal in U format (ERROR).
  - A delimiter (' ', ',', '\n') ends the field and is handled as in SEP.
  - `imm` = neg ? −acc : acc, truncated to IMM_W. For I format the 12-bit result is sign-extended.
- SEP (after a completed operand):
  - ' ' is skipped.
  - ',' when more operands remain advances the index and goes to OPERAND.
  - '\n' when no operands remain goes to DONE.
  - ',' with no operands remaining is ERROR.
  - '\n' with operands remaining is ERROR.
  - Any other character is ERROR.
- DONE: pulses `done_flag` for one cycle, then goes to IDLE. Fields hold until the next `start`.
- ERROR: ignores characters and holds until `start` or reset.
- IDLE: ignores `char_valid`.

## Timing

- Reset (asynchronous): state IDLE; every output is 0.
- One character is consumed per `char_valid` cycle; cycles without `char_valid` hold state.
- Fields are registered, updated the cycle after the completing character is sampled.
- `done_flag` is high the cycle after '\n' is sampled. `error_flag` rises the cycle after the offending character is sampled.
- `start` together with `char_valid` in the same cycle: the character is dropped.
- `start` in any state (including mid-line or ERROR) aborts and restarts. `done_flag` is not asserted for the aborted line.
- Reset mid-line returns to IDLE immediately, with no done or error pulse.

## Test plan

- R: `start`, format=0, "r01, r02,r31\n" → `done_flag` pulse; rd=1, rs1=2, rs2=31; `error_flag`=0.
- I negative limit: format=1, "r05,r00,-2048\n" → done; rd=5, rs1=0, imm=0xFF800. Then "r05,r00,2048\n" → `error_flag` rises after the final '8'; no done.
- U: format=2, "r10, 1048575\n" → imm=0xFFFFF. "r10,1048576\n" → error. "r10,-1\n" → error on '-'.
- Register checks: "r32,..." → error after '2'. "r3," → error at ','. Early '\n' after two R operands → error.
- Abort and reset: `start` issued mid-line with a char in the same cycle → char dropped; a fresh line parses correctly. `rst_in` asserted mid-line → all outputs 0 immediately and `busy`=0.

Source files
------------

// File: rtl/operand_sequencer_if.sv
// Handshake and result bundle between the mnemonic decoder, the operand
// sequencer and the instruction encoder.
interface operand_sequencer_if #(
  parameter int IMM_W = 20
);
  logic             start;
  logic [1:0]       format;
  logic             char_valid;
  logic [7:0]       char_in;
  logic             busy;
  logic             done_flag;
  logic             error_flag;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [IMM_W-1:0] imm;

  modport master (
    output start, format, char_valid, char_in,
    input  busy, done_flag, error_flag, rd, rs1, rs2, imm
  );

  modport slave (
    input  start, format, char_valid, char_in,
    output busy, done_flag, error_flag, rd, rs1, rs2, imm
  );
endinterface

// File: rtl/operand_sequencer.sv
// Walks the operand list of one assembly line character by character and
// produces validated register numbers and a sign-extended immediate.
module operand_sequencer #(
  parameter int IMM_W = 20
) (
  input logic                 clk_in,
  input logic                 rst_in,
  operand_sequencer_if.slave  seq
);
  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_OPERAND    = 4'd1;
  localparam logic [3:0] S_REG_D1     = 4'd2;
  localparam logic [3:0] S_REG_D2     = 4'd3;
  localparam logic [3:0] S_REG_END    = 4'd4;
  localparam logic [3:0] S_IMM_FIRST  = 4'd5;
  localparam logic [3:0] S_IMM_DIGITS = 4'd6;
  localparam logic [3:0] S_SEP        = 4'd7;
  localparam logic [3:0] S_DONE       = 4'd8;
  localparam logic [3:0] S_ERROR      = 4'd9;

  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_U   = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;

  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  logic [3:0]       state_reg, state_next;
  logic [1:0]       fmt_reg, fmt_next;
  logic [1:0]       idx_reg, idx_next;
  logic [20:0]      acc_reg, acc_next;
  logic             neg_reg, neg_next;
  logic [5:0]       regv_reg, regv_next;
  logic [4:0]       rd_reg, rd_next, rs1_reg, rs1_next, rs2_reg, rs2_next;
  logic [IMM_W-1:0] imm_reg, imm_next;

  logic        is_digit, is_delim, last_slot, imm_slot;
  logic [3:0]  digit;
  logic [5:0]  reg_sum;
  logic [24:0] acc_mul, imm_limit;
  logic [3:0]  sep_state;
  logic [1:0]  sep_idx;

  // Immediate as the encoder sees it; I-format values are 12-bit and sign-extended.
  function automatic logic [IMM_W-1:0] imm_of(input logic [20:0] mag, input logic neg,
                                               input logic [1:0] fmt);
    logic [IMM_W-1:0] mag_w;
    logic [IMM_W-1:0] full;
    mag_w = IMM_W'(mag);
    full  = neg ? (-mag_w) : mag_w;
    if (fmt == FMT_I)
      return {{(IMM_W-12){full[11]}}, full[11:0]};
    return full;
  endfunction

  always_comb begin
    is_digit  = (seq.char_in >= 8'h30) && (seq.char_in <= 8'h39);
    digit     = seq.char_in[3:0];
    is_delim  = (seq.char_in == CH_SP) || (seq.char_in == CH_COMMA) || (seq.char_in == CH_NL);
    last_slot = (fmt_reg == FMT_U) ? (idx_reg == 2'd1) : (idx_reg == 2'd2);
    imm_slot  = ((fmt_reg == FMT_I) && (idx_reg == 2'd2)) ||
                ((fmt_reg == FMT_U) && (idx_reg == 2'd1));
    reg_sum   = regv_reg + 6'(digit);
    acc_mul   = {4'd0, acc_reg} * 25'd10 + 25'(digit);
    imm_limit = (fmt_reg == FMT_U) ? 25'd1048575 : (neg_reg ? 25'd2048 : 25'd2047);
  end

  // Delimiter handling shared by SEP, REG_END and IMM_DIGITS.
  always_comb begin
    sep_state = S_ERROR;
    sep_idx   = idx_reg;
    if (seq.char_in == CH_SP) begin
      sep_state = S_SEP;
    end else if ((seq.char_in == CH_COMMA) && !last_slot) begin
      sep_state = S_OPERAND;
      sep_idx   = idx_reg + 2'd1;
    end else if ((seq.char_in == CH_NL) && last_slot) begin
      sep_state = S_DONE;
    end
  end

  always_comb begin
    state_next = state_reg;
    fmt_next   = fmt_reg;
    idx_next   = idx_reg;
    acc_next   = acc_reg;
    neg_next   = neg_reg;
    regv_next  = regv_reg;
    rd_next    = rd_reg;
    rs1_next   = rs1_reg;
    rs2_next   = rs2_reg;
    imm_next   = imm_reg;
    if (seq.start) begin
      fmt_next   = seq.format;
      idx_next   = 2'd0;
      acc_next   = '0;
      neg_next   = 1'b0;
      regv_next  = '0;
      rd_next    = '0;
      rs1_next   = '0;
      rs2_next   = '0;
      imm_next   = '0;
      state_next = (seq.format == FMT_BAD) ? S_ERROR : S_OPERAND;
    end else if (state_reg == S_DONE) begin
      state_next = S_IDLE;
    end else if (seq.char_valid && (state_reg != S_IDLE) && (state_reg != S_ERROR)) begin
      state_next = S_ERROR;
      case (state_reg)
        S_OPERAND: begin
          if (seq.char_in == CH_SP) begin
            state_next = S_OPERAND;
          end else if (!imm_slot && ((seq.char_in == 8'h72) || (seq.char_in == 8'h52))) begin
            state_next = S_REG_D1;
          end else if (imm_slot && (seq.char_in == CH_MINUS) && (fmt_reg != FMT_U)) begin
            neg_next   = 1'b1;
            state_next = S_IMM_FIRST;
          end else if (imm_slot && is_digit) begin
            acc_next   = 21'(digit);
            imm_next   = imm_of(21'(digit), neg_reg, fmt_reg);
            state_next = S_IMM_DIGITS;
          end
        end
        S_REG_D1: begin
          if ((seq.char_in >= 8'h30) && (seq.char_in <= 8'h33)) begin
            regv_next  = 6'(digit) * 6'd10;
            state_next = S_REG_D2;
          end
        end
        S_REG_D2: begin
          if (is_digit && (reg_sum <= 6'd31)) begin
            case (idx_reg)
              2'd0:    rd_next  = reg_sum[4:0];
              2'd1:    rs1_next = reg_sum[4:0];
              default: rs2_next = reg_sum[4:0];
            endcase
            state_next = S_REG_END;
          end
        end
        S_REG_END: begin
          if (is_delim) begin
            state_next = sep_state;
            idx_next   = sep_idx;
          end
        end
        S_IMM_FIRST: begin
          if (is_digit) begin
            acc_next   = 21'(digit);
            imm_next   = imm_of(21'(digit), neg_reg, fmt_reg);
            state_next = S_IMM_DIGITS;
          end
        end
        S_IMM_DIGITS: begin
          if (is_digit && (acc_mul <= imm_limit)) begin
            acc_next   = acc_mul[20:0];
            imm_next   = imm_of(acc_mul[20:0], neg_reg, fmt_reg);
            state_next = S_IMM_DIGITS;
          end else if (is_delim) begin
            state_next = sep_state;
            idx_next   = sep_idx;
          end
        end
        S_SEP: begin
          state_next = sep_state;
          idx_next   = sep_idx;
        end
        default: state_next = S_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= S_IDLE;
      fmt_reg   <= '0;
      idx_reg   <= '0;
      acc_reg   <= '0;
      neg_reg   <= 1'b0;
      regv_reg  <= '0;
      rd_reg    <= '0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      imm_reg   <= '0;
    end else begin
      state_reg <= state_next;
      fmt_reg   <= fmt_next;
      idx_reg   <= idx_next;
      acc_reg   <= acc_next;
      neg_reg   <= neg_next;
      regv_reg  <= regv_next;
      rd_reg    <= rd_next;
      rs1_reg   <= rs1_next;
      rs2_reg   <= rs2_next;
      imm_reg   <= imm_next;
    end
  end

  assign seq.busy       = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_ERROR);
  assign seq.done_flag  = (state_reg == S_DONE);
  assign seq.error_flag = (state_reg == S_ERROR);
  assign seq.rd         = rd_reg;
  assign seq.rs1        = rs1_reg;
  assign seq.rs2        = rs2_reg;
  assign seq.imm        = imm_reg;
endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: a table of whole lines plus
// hand-written abort, reset and error-timing sequences.
module tb_operand_sequencer;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  operand_sequencer_if #(.IMM_W(20)) bus ();
  operand_sequencer #(.IMM_W(20)) dut (.clk_in(clk_in), .rst_in(rst_in), .seq(bus));

  typedef struct packed {
    logic [1:0]   fmt;
    logic [159:0] text;
    logic [7:0]   len;
    logic         ok;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [19:0]  imm;
  } vec_t;

  vec_t vecs [16];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;

  function automatic vec_t mk(input logic [1:0] f, input string s, input logic ok,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [19:0] imm);
    vec_t v;
    v.fmt  = f;
    v.text = '0;
    for (int i = 0; i < s.len(); i++) v.text = {v.text[151:0], s[i]};
    v.len  = 8'(s.len());
    v.ok   = ok;
    v.rd   = rd;
    v.rs1  = rs1;
    v.rs2  = rs2;
    v.imm  = imm;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    bus.char_valid = 1'b1;
    bus.char_in    = c;
    @(posedge clk_in);
    #1;
    if (bus.done_flag) done_cnt++;
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      if (bus.done_flag) done_cnt++;
    end
  endtask

  task automatic do_start(input logic [1:0] f);
    bus.start  = 1'b1;
    bus.format = f;
    @(posedge clk_in);
    #1;
    bus.start = 1'b0;
    done_cnt  = 0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.format     = 2'd0;
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;

    vecs[0]  = mk(2'd0, "r01, r02,r31\n",        1'b1, 5'd1,  5'd2,  5'd31, 20'h00000);
    vecs[1]  = mk(2'd1, "r05,r00,-2048\n",       1'b1, 5'd5,  5'd0,  5'd0,  20'hFF800);
    vecs[2]  = mk(2'd1, "r05,r00,2048\n",        1'b0, 5'd0,  5'd0,  5'd0,  20'h0);
    vecs[3]  = mk(2'd2, "r10, 1048575\n",        1'b1, 5'd10, 5'd0,  5'd0,  20'hFFFFF);
    vecs[4]  = mk(2'd2, "r10,1048576\n",         1'b0, 5'd0,  5'd0,  5'd0,  20'h0);
    vecs[5]  = mk(2'd2, "r10,-1\n",              1'b0, 5'd0,  5'd0,  5'd0,  20'h0);
    vecs[6]  = mk(2'd0, "r32,r01,r02\n",         1'b0, 5'd0,  5'd0,  5'd0,  20'h0);
    vecs[7]  = mk(2'd0, "r3,r01,r02\n",          1'b0, 5'd0,  5'd0,  5'd0,  20'h0);
    vecs[8]  = mk(2'd0, "r01,r02\n",             1'b0, 5'd0,  5'd0,  5'd0,  20'h0);
    vecs[9]  = mk(2'd1, "r07 , r08 , 2047 \n",   1'b1, 5'd7,  5'd8,  5'd0,  20'h007FF);
    vecs[10] = mk(2'd1, "r00,r31,-1\n",          1'b1, 5'd0,  5'd31, 5'd0,  20'hFFFFF);
    vecs[11] = mk(2'd3, "r01\n",                 1'b0, 5'd0,  5'd0,  5'd0,  20'h0);
    vecs[12] = mk(2'd0, "r01,r02,r03,\n",        1'b0, 5'd0,  5'd0,  5'd0,  20'h0);
    vecs[13] = mk(2'd1, "r01,r02,x\n",           1'b0, 5'd0,  5'd0,  5'd0,  20'h0);
    vecs[14] = mk(2'd2, "r09,0\n",               1'b1, 5'd9,  5'd0,  5'd0,  20'h00000);
    vecs[15] = mk(2'd1, "R12,r13,-2049\n",       1'b0, 5'd0,  5'd0,  5'd0,  20'h0);

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    check("reset busy",  32'(bus.busy), 32'd0);
    check("reset done",  32'(bus.done_flag), 32'd0);
    check("reset error", 32'(bus.error_flag), 32'd0);
    check("reset fields", {7'd0, bus.rd, bus.rs1, bus.rs2, bus.imm[9:0]}, 32'd0);
    rst_in = 1'b0;

    // IDLE ignores characters
    done_cnt = 0;
    send_str("r01\n");
    idle(2);
    check("idle busy", 32'(bus.busy), 32'd0);
    check("idle done", 32'(done_cnt), 32'd0);
    check("idle rd",   32'(bus.rd), 32'd0);

    for (int i = 0; i < 16; i++) begin
      do_start(vecs[i].fmt);
      for (int k = 0; k < int'(vecs[i].len); k++)
        send_char(vecs[i].text[8*(int'(vecs[i].len)-1-k) +: 8]);
      idle(3);
      $display("[TB] vec %0d fmt=%0d done_pulses=%0d err=%0d rd=%0d rs1=%0d rs2=%0d imm=%05h",
               i, vecs[i].fmt, done_cnt, bus.error_flag, bus.rd, bus.rs1, bus.rs2, bus.imm);
      check($sformatf("v%0d done", i),  32'(done_cnt), vecs[i].ok ? 32'd1 : 32'd0);
      check($sformatf("v%0d error", i), 32'(bus.error_flag), vecs[i].ok ? 32'd0 : 32'd1);
      check($sformatf("v%0d busy", i),  32'(bus.busy), 32'd0);
      if (vecs[i].ok) begin
        check($sformatf("v%0d rd", i),  32'(bus.rd),  32'(vecs[i].rd));
        check($sformatf("v%0d rs1", i), 32'(bus.rs1), 32'(vecs[i].rs1));
        check($sformatf("v%0d rs2", i), 32'(bus.rs2), 32'(vecs[i].rs2));
        check($sformatf("v%0d imm", i), 32'(bus.imm), 32'(vecs[i].imm));
      end
    end

    // Error rises exactly the cycle after the offending '8'
    do_start(2'd1);
    send_str("r05,r00,204");
    check("lim pre err", 32'(bus.error_flag), 32'd0);
    check("lim pre busy", 32'(bus.busy), 32'd1);
    send_char(8'h38);
    check("lim post err", 32'(bus.error_flag), 32'd1);
    $display("[TB] limit timing err=%0d", bus.error_flag);

    // Error on ',' after a single register digit
    do_start(2'd0);
    send_str("r3");
    check("r3 pre err", 32'(bus.error_flag), 32'd0);
    send_char(8'h2C);
    check("r3 post err", 32'(bus.error_flag), 32'd1);
    $display("[TB] short register err=%0d", bus.error_flag);

    // Abort mid-line with a character in the start cycle
    do_start(2'd0);
    send_str("r01,r");
    bus.start      = 1'b1;
    bus.format     = 2'd1;
    bus.char_valid = 1'b1;
    bus.char_in    = 8'h78;
    @(posedge clk_in);
    #1;
    bus.start      = 1'b0;
    bus.char_valid = 1'b0;
    done_cnt       = 0;
    check("abort busy", 32'(bus.busy), 32'd1);
    check("abort err",  32'(bus.error_flag), 32'd0);
    check("abort rd cleared", 32'(bus.rd), 32'd0);
    send_str("r02,r03,-5\n");
    idle(2);
    $display("[TB] abort restart done_pulses=%0d rd=%0d rs1=%0d imm=%05h",
             done_cnt, bus.rd, bus.rs1, bus.imm);
    check("abort done", 32'(done_cnt), 32'd1);
    check("abort rd",   32'(bus.rd), 32'd2);
    check("abort rs1",  32'(bus.rs1), 32'd3);
    check("abort imm",  32'(bus.imm), 32'hFFFFB);

    // Asynchronous reset mid-line
    do_start(2'd0);
    send_str("r01,r0");
    check("pre rst rd", 32'(bus.rd), 32'd1);
    #2 rst_in = 1'b1;
    #1;
    check("rst busy",  32'(bus.busy), 32'd0);
    check("rst rd",    32'(bus.rd), 32'd0);
    check("rst done",  32'(bus.done_flag), 32'd0);
    check("rst error", 32'(bus.error_flag), 32'd0);
    $display("[TB] mid-line reset busy=%0d rd=%0d", bus.busy, bus.rd);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
